branch_hazard_unit: RTL and testbench
=====================================

BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter IDX_W, default 4, predictor index width (2**IDX_W entries).
REQ-003 SHALL have ports CLK input 1 (single clock) and RSTn input 1 (asynchronous, active-low reset).
REQ-004 SHALL have port IF_PC input XLEN, fetch-stage PC for lookup.
REQ-005 SHALL have ports Pred_Taken output 1 and Pred_Target output XLEN, prediction for IF_PC.
REQ-006 SHALL have port Resolve_Valid input 1, EX/MEM holds a valid resolving instruction.
REQ-007 SHALL have port Resolve_PC input XLEN, PC of the resolving instruction.
REQ-008 SHALL have port PCSrc input 2, with encoding 00 none, 01 JAL, 10 JALR, 11 branch.
REQ-009 SHALL have ports BranchCond input 1 and ALUOUT_EXMEM input XLEN, branch outcome and computed target.
REQ-010 SHALL have ports Resolve_PredTaken input 1 and Resolve_PredTarget input XLEN, prediction carried down the pipe.
REQ-011 SHALL have ports Updated_PC output XLEN, Hazard_Sig output 1, and FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM output 1 each.

Function
REQ-012 SHALL hold 2**IDX_W entries, each with valid, tag (XLEN-IDX_W-2 bits), target (XLEN), and a 2-bit saturating counter.
REQ-013 SHALL compute index as PC[IDX_W+1:2] and tag as PC[XLEN-1:IDX_W+2].
REQ-014 SHALL assert Pred_Taken combinationally when IF_PC hits a valid entry with counter[1]=1, with Pred_Target equal to the entry target; otherwise Pred_Taken=0 and Pred_Target=IF_PC+4.
REQ-015 SHALL define actual taken as JAL, JALR, or (branch AND BranchCond), and actual target as ALUOUT_EXMEM, or ALUOUT_EXMEM & ~1 for JALR.
REQ-016 SHALL define a mispredict as Resolve_Valid AND PCSrc!=00 AND (taken!=Resolve_PredTaken OR (taken AND target!=Resolve_PredTarget)).
REQ-017 SHALL, on a mispredict, drive Hazard_Sig and all three FLUSH outputs to 1 combinationally in the same cycle, with Updated_PC = actual target if taken, else Resolve_PC+4.
REQ-018 SHALL, with no mispredict, drive Hazard_Sig=0, all FLUSH outputs 0, and Updated_PC=0.
REQ-019 SHALL update the table on the rising CLK edge when Resolve_Valid=1 and PCSrc!=00; no update otherwise.
REQ-020 SHALL, for a branch hit, increment the counter if taken and decrement it if not taken, saturating at 11 and 00, and refresh the target when taken.
REQ-021 SHALL, for a branch miss, allocate the entry (overwriting) with counter 10 and the target only if taken; a not-taken miss leaves the table unchanged.
REQ-022 SHALL, for JAL/JALR, write valid, tag, target, and counter 11 regardless of hit.
REQ-023 SHALL, when a lookup and an update hit the same index in the same cycle, return the pre-update contents to the lookup (no bypass).
REQ-024 SHALL compute all PC+4 arithmetic modulo 2**XLEN (wrap-around, no carry out).

Reset
REQ-025 SHALL, while RSTn=0, asynchronously clear every valid bit and set every counter to 01, including mid-update.
REQ-026 SHALL, after reset, output Pred_Taken=0 and Pred_Target=IF_PC+4, with Hazard_Sig/FLUSH_* 0 and Updated_PC=0 while no resolve is active.

Configuration
REQ-027 SHALL, with HAZARD_PERF_CNT_EN defined, add outputs Branch_Cnt and Mispred_Cnt (32 bits each), counting resolves with PCSrc!=00 and mispredicts, saturating at all-ones and cleared by reset.
REQ-028 SHALL, without HAZARD_PERF_CNT_EN, omit those ports and counters entirely, with behaviour otherwise identical.

Structure
REQ-029 SHALL place the PCSrc encodings, counter reset/allocate constants, and the PC increment constant 4 in shared package hazard_pkg.
REQ-030 SHALL implement entry storage, lookup, and update in one sub-module named btb_table; mispredict and flush logic SHALL reside in branch_hazard_unit.

Verification
REQ-031 SHALL cover: reset, then IF_PC=0x100 -> Pred_Taken=0 and Pred_Target=0x104.
REQ-032 SHALL cover: resolve JAL at 0x100, target 0x200, PredTaken=0 -> flush all, Updated_PC=0x200; next cycle IF_PC=0x100 -> Pred_Taken=1 and Pred_Target=0x200.
REQ-033 SHALL cover: resolve branch at 0x40, BranchCond=0, PredTaken=1, PredTarget=0x80 -> Updated_PC=0x44 and flush; counter 11 -> 10.
REQ-034 SHALL cover: JALR with ALUOUT_EXMEM=0x301 -> Updated_PC=0x300.
REQ-035 SHALL cover: correct prediction (taken, matching target) -> Hazard_Sig=0 and no flush; counter saturates at 11 after repeats.
REQ-036 SHALL cover: RSTn pulsed low mid-run -> next lookups all miss; with HAZARD_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the branch hazard unit: PCSrc encodings, predictor
// counter values and the sequential PC increment.
package hazard_pkg;

   typedef enum logic [1:0] {
      PCSRC_NONE = 2'b00,
      PCSRC_JAL  = 2'b01,
      PCSRC_JALR = 2'b10,
      PCSRC_BR   = 2'b11
   } pcsrc_e;

   localparam logic [1:0] CTR_MIN   = 2'b00;
   localparam logic [1:0] CTR_RST   = 2'b01;
   localparam logic [1:0] CTR_ALLOC = 2'b10;
   localparam logic [1:0] CTR_MAX   = 2'b11;

   localparam int unsigned PC_INC = 4;

   // 2-bit saturating counter step
   function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
      if (up) return (c == CTR_MAX) ? CTR_MAX : c + 2'd1;
      else    return (c == CTR_MIN) ? CTR_MIN : c - 2'd1;
   endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: combinational lookup for fetch, one
// registered update per cycle from the resolving instruction.
module btb_table
   import hazard_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int IDX_W = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [XLEN-1:0] lk_pc_i,
   output logic            lk_taken_o,
   output logic [XLEN-1:0] lk_tgt_o,
   input  logic            up_en_i,
   input  logic            up_jump_i,
   input  logic            up_taken_i,
   input  logic [XLEN-1:0] up_pc_i,
   input  logic [XLEN-1:0] up_tgt_i
);

   localparam int TAG_W   = XLEN - IDX_W - 2;
   localparam int ENTRIES = 1 << IDX_W;

   logic [ENTRIES-1:0]            vld_q;
   logic [ENTRIES-1:0][1:0]       ctr_q;
   logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
   logic [ENTRIES-1:0][XLEN-1:0]  tgt_q;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             lk_hit, up_hit;
   logic             alloc, tgt_we, ctr_we;
   logic [1:0]       ctr_d;
   logic             unused_pc_lsb;

   assign lk_idx = lk_pc_i[IDX_W+1:2];
   assign lk_tag = lk_pc_i[XLEN-1:IDX_W+2];
   assign up_idx = up_pc_i[IDX_W+1:2];
   assign up_tag = up_pc_i[XLEN-1:IDX_W+2];
   assign unused_pc_lsb = ^{lk_pc_i[1:0], up_pc_i[1:0]};

   // Lookup reads the registered state only, so a same-cycle update is not bypassed
   assign lk_hit     = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_taken_o = lk_hit && ctr_q[lk_idx][1];
   assign lk_tgt_o   = lk_taken_o ? tgt_q[lk_idx] : lk_pc_i + XLEN'(PC_INC);

   assign up_hit = vld_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_comb begin
      alloc  = 1'b0;
      tgt_we = 1'b0;
      ctr_we = 1'b0;
      ctr_d  = ctr_q[up_idx];
      if (up_en_i) begin
         if (up_jump_i) begin
            alloc  = 1'b1;
            tgt_we = 1'b1;
            ctr_we = 1'b1;
            ctr_d  = CTR_MAX;
         end else if (up_hit) begin
            ctr_we = 1'b1;
            ctr_d  = ctr_step(ctr_q[up_idx], up_taken_i);
            tgt_we = up_taken_i;
         end else if (up_taken_i) begin
            // not-taken misses are not worth an entry
            alloc  = 1'b1;
            tgt_we = 1'b1;
            ctr_we = 1'b1;
            ctr_d  = CTR_ALLOC;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         ctr_q <= {ENTRIES{CTR_RST}};
      end else begin
         if (alloc)  vld_q[up_idx] <= 1'b1;
         if (ctr_we) ctr_q[up_idx] <= ctr_d;
      end
   end

   // Tag/target need no reset: they are qualified by vld_q
   always_ff @(posedge clk_i) begin
      if (alloc)  tag_q[up_idx] <= up_tag;
      if (tgt_we) tgt_q[up_idx] <= up_tgt_i;
   end

endmodule

// File: rtl/branch_hazard_unit.sv
// Branch prediction and mispredict recovery. Define HAZARD_PERF_CNT_EN to add
// the Branch_Cnt / Mispred_Cnt performance counters.
module branch_hazard_unit
   import hazard_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int IDX_W = 4
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic [XLEN-1:0] IF_PC,
   output logic            Pred_Taken,
   output logic [XLEN-1:0] Pred_Target,
   input  logic            Resolve_Valid,
   input  logic [XLEN-1:0] Resolve_PC,
   input  logic [1:0]      PCSrc,
   input  logic            BranchCond,
   input  logic [XLEN-1:0] ALUOUT_EXMEM,
   input  logic            Resolve_PredTaken,
   input  logic [XLEN-1:0] Resolve_PredTarget,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]     Branch_Cnt,
   output logic [31:0]     Mispred_Cnt,
`endif
   output logic [XLEN-1:0] Updated_PC,
   output logic            Hazard_Sig,
   output logic            FLUSH_IFID,
   output logic            FLUSH_IDEX,
   output logic            FLUSH_EXMEM
);

   pcsrc_e          src;
   logic            is_jump, resolving, taken, mispred;
   logic [XLEN-1:0] act_tgt;

   assign src       = pcsrc_e'(PCSrc);
   assign is_jump   = (src == PCSRC_JAL) || (src == PCSRC_JALR);
   assign resolving = Resolve_Valid && (src != PCSRC_NONE);
   assign taken     = is_jump || ((src == PCSRC_BR) && BranchCond);
   assign act_tgt   = (src == PCSRC_JALR) ? (ALUOUT_EXMEM & ~XLEN'(1)) : ALUOUT_EXMEM;

   assign mispred = resolving &&
                    ((taken != Resolve_PredTaken) ||
                     (taken && (act_tgt != Resolve_PredTarget)));

   assign Hazard_Sig  = mispred;
   assign FLUSH_IFID  = mispred;
   assign FLUSH_IDEX  = mispred;
   assign FLUSH_EXMEM = mispred;
   assign Updated_PC  = !mispred ? '0 :
                        taken    ? act_tgt : Resolve_PC + XLEN'(PC_INC);

   btb_table #(.XLEN(XLEN), .IDX_W(IDX_W)) u_btb (
      .clk_i      (CLK),
      .rst_ni     (RSTn),
      .lk_pc_i    (IF_PC),
      .lk_taken_o (Pred_Taken),
      .lk_tgt_o   (Pred_Target),
      .up_en_i    (resolving),
      .up_jump_i  (is_jump),
      .up_taken_i (taken),
      .up_pc_i    (Resolve_PC),
      .up_tgt_i   (act_tgt)
   );

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (resolving && (branch_cnt_q != '1))  branch_cnt_d  = branch_cnt_q + 32'd1;
      if (mispred   && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 32'd1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign Branch_Cnt  = branch_cnt_q;
   assign Mispred_Cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit; also checks the perf counters when
// HAZARD_PERF_CNT_EN is defined.
module tb_branch_hazard_unit;

   localparam logic [1:0] NONE = 2'b00, JAL = 2'b01, JALR = 2'b10, BR = 2'b11;

   logic        CLK, RSTn;
   logic [31:0] IF_PC, Pred_Target, Resolve_PC, ALUOUT_EXMEM, Resolve_PredTarget, Updated_PC;
   logic        Pred_Taken, Resolve_Valid, BranchCond, Resolve_PredTaken;
   logic [1:0]  PCSrc;
   logic        Hazard_Sig, FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] Branch_Cnt, Mispred_Cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   branch_hazard_unit #(.XLEN(32), .IDX_W(4)) dut (
      .CLK                (CLK),
      .RSTn               (RSTn),
      .IF_PC              (IF_PC),
      .Pred_Taken         (Pred_Taken),
      .Pred_Target        (Pred_Target),
      .Resolve_Valid      (Resolve_Valid),
      .Resolve_PC         (Resolve_PC),
      .PCSrc              (PCSrc),
      .BranchCond         (BranchCond),
      .ALUOUT_EXMEM       (ALUOUT_EXMEM),
      .Resolve_PredTaken  (Resolve_PredTaken),
      .Resolve_PredTarget (Resolve_PredTarget),
`ifdef HAZARD_PERF_CNT_EN
      .Branch_Cnt         (Branch_Cnt),
      .Mispred_Cnt        (Mispred_Cnt),
`endif
      .Updated_PC         (Updated_PC),
      .Hazard_Sig         (Hazard_Sig),
      .FLUSH_IFID         (FLUSH_IFID),
      .FLUSH_IDEX         (FLUSH_IDEX),
      .FLUSH_EXMEM        (FLUSH_EXMEM)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] src,
                        input logic cond, input logic [31:0] alu,
                        input logic pt, input logic [31:0] ptgt);
      Resolve_Valid      = v;
      Resolve_PC         = pc;
      PCSrc              = src;
      BranchCond         = cond;
      ALUOUT_EXMEM       = alu;
      Resolve_PredTaken  = pt;
      Resolve_PredTarget = ptgt;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, NONE, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic exp_res(input string tag, input logic hz, input logic [31:0] upc);
      chk({tag, ".hz"},    Hazard_Sig, hz);
      chk({tag, ".flush"}, {FLUSH_IFID, FLUSH_IDEX, FLUSH_EXMEM}, {3{hz}});
      chk({tag, ".upc"},   Updated_PC, upc);
   endtask

   task automatic exp_look(input string tag, input logic [31:0] pc,
                           input logic tk, input logic [31:0] tgt);
      IF_PC = pc;
      #1;
      chk({tag, ".tk"},  Pred_Taken, tk);
      chk({tag, ".tgt"}, Pred_Target, tgt);
   endtask

   // One resolve in the cycle ending at the next posedge; checks flush outputs
   task automatic step(input string tag, input logic v, input logic [31:0] pc,
                       input logic [1:0] src, input logic cond, input logic [31:0] alu,
                       input logic pt, input logic [31:0] ptgt,
                       input logic hz, input logic [31:0] upc);
      @(negedge CLK);
      drive(v, pc, src, cond, alu, pt, ptgt);
      #1;
      exp_res(tag, hz, upc);
   endtask

   initial begin
      RSTn  = 1'b0;
      IF_PC = 32'h100;
      idle();
      repeat (2) @(negedge CLK);
      exp_look("rst_look", 32'h100, 1'b0, 32'h104);
      exp_res("rst_idle", 1'b0, 32'h0);
      @(negedge CLK);
      RSTn = 1'b1;
      @(negedge CLK);
      exp_look("post_rst", 32'h100, 1'b0, 32'h104);

      // JAL mispredicted not-taken; same-cycle lookup sees pre-update table
      step("jal_mp", 1, 32'h100, JAL, 0, 32'h200, 0, 32'h104, 1, 32'h200);
      exp_look("jal_nobyp", 32'h100, 1'b0, 32'h104);
      @(negedge CLK); idle();
      exp_look("jal_hit", 32'h100, 1'b1, 32'h200);

      step("jal_badtgt", 1, 32'h100, JAL, 0, 32'h200, 1, 32'h204, 1, 32'h200);
      step("jal_ok",     1, 32'h100, JAL, 0, 32'h200, 1, 32'h200, 0, 32'h0);

      // Resolve_Valid low: no flush and no table write
      step("inval", 0, 32'h500, JALR, 0, 32'h300, 0, 32'h0, 0, 32'h0);
      @(negedge CLK); idle();
      exp_look("inval_look", 32'h500, 1'b0, 32'h504);
      exp_look("inval_keep", 32'h100, 1'b1, 32'h200);

      // JALR clears bit 0; 0x500 shares index 0 with 0x100 and evicts it
      step("jalr", 1, 32'h500, JALR, 0, 32'h301, 0, 32'h504, 1, 32'h300);
      @(negedge CLK); idle();
      exp_look("jalr_hit", 32'h500, 1'b1, 32'h300);
      exp_look("evicted",  32'h100, 1'b0, 32'h104);

      // Not-taken branch miss at colliding index leaves the entry alone
      step("nt_miss", 1, 32'h600, BR, 0, 32'h0, 0, 32'h604, 0, 32'h0);
      @(negedge CLK); idle();
      exp_look("nt_miss_keep", 32'h500, 1'b1, 32'h300);
      exp_look("nt_miss_look", 32'h600, 1'b0, 32'h604);

      // Branch at 0x40: allocate at 10, saturate at 11, then walk down
      step("br_alloc", 1, 32'h40, BR, 1, 32'h80, 0, 32'h44, 1, 32'h80);
      step("br_ok1",   1, 32'h40, BR, 1, 32'h80, 1, 32'h80, 0, 32'h0);
      step("br_ok2",   1, 32'h40, BR, 1, 32'h80, 1, 32'h80, 0, 32'h0);
      @(negedge CLK); idle();
      exp_look("br_sat", 32'h40, 1'b1, 32'h80);
      step("br_nt1", 1, 32'h40, BR, 0, 32'h80, 1, 32'h80, 1, 32'h44);
      @(negedge CLK); idle();
      exp_look("br_ctr10", 32'h40, 1'b1, 32'h80);
      step("br_nt2", 1, 32'h40, BR, 0, 32'h80, 1, 32'h80, 1, 32'h44);
      @(negedge CLK); idle();
      exp_look("br_ctr01", 32'h40, 1'b0, 32'h44);
      step("br_nt3", 1, 32'h40, BR, 0, 32'h80, 0, 32'h44, 0, 32'h0);
      step("br_nt4", 1, 32'h40, BR, 0, 32'h80, 0, 32'h44, 0, 32'h0);
      @(negedge CLK); idle();
      exp_look("br_floor", 32'h40, 1'b0, 32'h44);
      // Branch targets are not masked, only JALR's
      step("br_odd", 1, 32'h40, BR, 1, 32'h81, 0, 32'h44, 1, 32'h81);

      // PC+4 wraps to zero
      step("wrap", 1, 32'hFFFF_FFFC, BR, 0, 32'h10, 1, 32'h10, 1, 32'h0);
      @(negedge CLK); idle();
      exp_look("wrap_look", 32'hFFFF_FFFC, 1'b0, 32'h0);

      // Reset asserted mid-cycle while an update is pending
      step("pre_rst", 1, 32'h104, JAL, 0, 32'h900, 0, 32'h108, 1, 32'h900);
      @(negedge CLK); idle();
      exp_look("pre_rst_hit", 32'h104, 1'b1, 32'h900);
      @(negedge CLK);
      drive(1, 32'h700, JAL, 0, 32'h900, 0, 32'h704);
      #2 RSTn = 1'b0;
      exp_look("async_clr", 32'h104, 1'b0, 32'h108);
      @(negedge CLK);
      RSTn = 1'b1;
      idle();
      exp_look("rst_miss1", 32'h104, 1'b0, 32'h108);
      exp_look("rst_miss2", 32'h700, 1'b0, 32'h704);
      exp_look("rst_miss3", 32'h500, 1'b0, 32'h504);
`ifdef HAZARD_PERF_CNT_EN
      chk("cnt_br_rst", Branch_Cnt, 32'd0);
      chk("cnt_mp_rst", Mispred_Cnt, 32'd0);
      step("cnt_mp", 1, 32'h10, BR, 0, 32'h80, 1, 32'h80, 1, 32'h14);
      step("cnt_ok", 1, 32'h10, BR, 0, 32'h80, 0, 32'h14, 0, 32'h0);
      @(negedge CLK); idle();
      #1;
      chk("cnt_br", Branch_Cnt, 32'd2);
      chk("cnt_mp", Mispred_Cnt, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
